// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers: occupancy
// state encodings and the default payload widths of each stage boundary.
package pipe_pkg;

  // Stage occupancy doubles as the FSM state: number of beats held.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } occ_state_t;

  // IF/ID: pc + instruction word, control is just a predicted-taken flag.
  localparam int FD_DATA_W = 64;
  localparam int FD_CTRL_W = 1;

  // ID/EX: pc + two operands, full decoded control.
  localparam int DE_DATA_W = 96;
  localparam int DE_CTRL_W = 16;

  // EX/MEM: ALU result + store data.
  localparam int EM_DATA_W = 64;
  localparam int EM_CTRL_W = 16;

  // MEM/WB: ALU result + load data, write-back enable/select/waddr.
  localparam int MW_DATA_W = 64;
  localparam int MW_CTRL_W = 8;

endpackage

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline register between two CPU stages. Holds one
// data bus and one control bus per beat, with an optional two-entry skid
// buffer that registers in_ready, synchronous flush for squashing, and an
// occupancy report for the hazard unit. out_ctrl is forced to CTRL_RST
// whenever no beat is presented, so downstream enables need no gating.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                CTRL_W   = 16,
  parameter logic [CTRL_W-1:0] CTRL_RST = '0,
  parameter int                SKID     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  occ_state_t        state_p1;
  occ_state_t        state_nxt;
  logic              vld_p1;
  logic [DATA_W-1:0] main_data_p1;
  logic [CTRL_W-1:0] main_ctrl_p1;
  logic              in_hs;
  logic              out_hs;

  assign in_hs     = in_valid & in_ready;
  assign out_hs    = vld_p1 & out_ready;
  assign out_valid = vld_p1;
  assign out_data  = main_data_p1;
  assign out_ctrl  = vld_p1 ? main_ctrl_p1 : CTRL_RST;
  assign occupancy = state_p1;

  if (SKID != 0) begin : g_skid

    logic              in_ready_p1;
    logic [DATA_W-1:0] skid_data_p1;
    logic [CTRL_W-1:0] skid_ctrl_p1;

    assign in_ready = in_ready_p1;

    // Next occupancy; flush overrides every handshake in the same cycle.
    always_comb begin
      state_nxt = state_p1;
      if (flush) begin
        state_nxt = ST_EMPTY;
      end else begin
        case (state_p1)
          ST_EMPTY: if (in_hs) state_nxt = ST_ONE;
          ST_ONE: begin
            if (in_hs && !out_hs)      state_nxt = ST_TWO;
            else if (!in_hs && out_hs) state_nxt = ST_EMPTY;
          end
          ST_TWO:   if (out_hs) state_nxt = ST_ONE;
          default:  state_nxt = ST_EMPTY;
        endcase
      end
    end

    // Control registers: in_ready is registered from the next state so it
    // never depends combinationally on out_ready.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_p1    <= ST_EMPTY;
        vld_p1      <= 1'b0;
        in_ready_p1 <= 1'b1;
      end else begin
        state_p1    <= state_nxt;
        vld_p1      <= (state_nxt != ST_EMPTY);
        in_ready_p1 <= (state_nxt != ST_TWO);
      end
    end

    // Payload entries: main feeds the output, skid holds the younger beat.
    // A flush leaves the payload untouched so out_data keeps its last value.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        main_data_p1 <= '0;
        main_ctrl_p1 <= CTRL_RST;
        skid_data_p1 <= '0;
        skid_ctrl_p1 <= CTRL_RST;
      end else if (!flush) begin
        case (state_p1)
          ST_EMPTY: begin
            if (in_hs) begin
              main_data_p1 <= in_data;
              main_ctrl_p1 <= in_ctrl;
            end
          end
          ST_ONE: begin
            if (in_hs && out_hs) begin
              main_data_p1 <= in_data;
              main_ctrl_p1 <= in_ctrl;
            end else if (in_hs) begin
              skid_data_p1 <= in_data;
              skid_ctrl_p1 <= in_ctrl;
            end
          end
          ST_TWO: begin
            if (out_hs) begin
              main_data_p1 <= skid_data_p1;
              main_ctrl_p1 <= skid_ctrl_p1;
            end
          end
          default: ;
        endcase
      end
    end

  end else begin : g_single

    // Single entry: accept when empty or when the held beat leaves now.
    assign in_ready = !vld_p1 | out_ready;

    // Next occupancy for the single-entry variant (never reaches TWO).
    always_comb begin
      state_nxt = state_p1;
      if (flush)       state_nxt = ST_EMPTY;
      else if (in_hs)  state_nxt = ST_ONE;
      else if (out_hs) state_nxt = ST_EMPTY;
    end

    // Control registers.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_p1 <= ST_EMPTY;
        vld_p1   <= 1'b0;
      end else begin
        state_p1 <= state_nxt;
        vld_p1   <= (state_nxt != ST_EMPTY);
      end
    end

    // Payload entry, loaded on every accepted beat unless squashed.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        main_data_p1 <= '0;
        main_ctrl_p1 <= CTRL_RST;
      end else if (!flush && in_hs) begin
        main_data_p1 <= in_data;
        main_ctrl_p1 <= in_ctrl;
      end
    end

  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: one skid-buffered instance and one
// single-entry instance (with a non-zero bubble control value).
module tb_pipe_stage_reg;

  logic        clk;
  logic        rst;

  // SKID=1 instance signals
  logic        v1, ir1, f1, ov1, r1;
  logic [31:0] d1, od1;
  logic [15:0] c1, oc1;
  logic [1:0]  occ1;

  // SKID=0 instance signals
  logic        v0, ir0, f0, ov0, r0;
  logic [31:0] d0, od0;
  logic [15:0] c0, oc0;
  logic [1:0]  occ0;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(16), .CTRL_RST(16'h0000), .SKID(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(v1), .in_ready(ir1), .in_data(d1), .in_ctrl(c1),
    .flush(f1),
    .out_valid(ov1), .out_ready(r1), .out_data(od1), .out_ctrl(oc1),
    .occupancy(occ1)
  );

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(16), .CTRL_RST(16'h5A5A), .SKID(0)) dut0 (
    .clk(clk), .rst(rst),
    .in_valid(v0), .in_ready(ir0), .in_data(d0), .in_ctrl(c0),
    .flush(f0),
    .out_valid(ov0), .out_ready(r0), .out_data(od0), .out_ctrl(oc0),
    .occupancy(occ0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    v1 = 0; f1 = 0; r1 = 0; d1 = 0; c1 = 0;
    v0 = 0; f0 = 0; r0 = 0; d0 = 0; c0 = 0;

    // Reset state
    step();
    chk("rst ov1", ov1, 0);
    chk("rst oc1", oc1, 16'h0000);
    chk("rst od1", od1, 0);
    chk("rst occ1", occ1, 0);
    chk("rst ir1", ir1, 1);
    chk("rst ov0", ov0, 0);
    chk("rst oc0", oc0, 16'h5A5A);
    chk("rst ir0", ir0, 1);
    rst = 1'b0;

    // Stream 1..4 with out_ready high
    r1 = 1; v1 = 1; c1 = 16'h0011;
    for (int i = 1; i <= 4; i++) begin
      d1 = i;
      step();
      chk("stream od1", od1, i);
      chk("stream ov1", ov1, 1);
      chk("stream occ1", occ1, 1);
      chk("stream ir1", ir1, 1);
      chk("stream oc1", oc1, 16'h0011);
    end
    v1 = 0;
    step();
    chk("drain ov1", ov1, 0);
    chk("drain occ1", occ1, 0);

    // Backpressure fill: A, B accepted, C held off
    r1 = 0; v1 = 1; d1 = 32'hA;
    step();
    chk("bp occ after A", occ1, 1);
    chk("bp od A", od1, 32'hA);
    chk("bp ir after A", ir1, 1);
    d1 = 32'hB;
    step();
    chk("bp occ after B", occ1, 2);
    chk("bp ir after B", ir1, 0);
    chk("bp od still A", od1, 32'hA);
    d1 = 32'hC;
    step();
    chk("bp occ C held", occ1, 2);
    chk("bp od A held", od1, 32'hA);
    r1 = 1;
    step();
    chk("bp od B", od1, 32'hB);
    chk("bp occ one", occ1, 1);
    chk("bp ir back", ir1, 1);
    step();
    chk("bp od C", od1, 32'hC);
    chk("bp ov C", ov1, 1);
    v1 = 0;
    step();
    chk("bp drained ov", ov1, 0);

    // Flush with full buffer holding 5, 6; beat 7 presented with flush
    r1 = 0; v1 = 1; d1 = 5; c1 = 16'h00F0;
    step();
    d1 = 6;
    step();
    chk("fl occ two", occ1, 2);
    f1 = 1; d1 = 7;
    step();
    chk("fl ov", ov1, 0);
    chk("fl oc", oc1, 16'h0000);
    chk("fl occ", occ1, 0);
    chk("fl od held", od1, 5);
    // Flush while empty with a completing input handshake, held 2 cycles
    d1 = 8; r1 = 1;
    chk("fl ir normal", ir1, 1);
    step();
    chk("fl2 ov", ov1, 0);
    step();
    chk("fl3 ov", ov1, 0);
    chk("fl3 occ", occ1, 0);
    f1 = 0; v1 = 0;
    step();
    chk("fl beat lost ov", ov1, 0);
    chk("fl beat lost od", od1, 5);

    // Asynchronous reset between edges while two beats are held
    r1 = 0; v1 = 1; d1 = 32'h21;
    step();
    d1 = 32'h22;
    step();
    v1 = 0;
    chk("ar occ two", occ1, 2);
    #2 rst = 1'b1;
    #1;
    chk("ar ov", ov1, 0);
    chk("ar oc", oc1, 16'h0000);
    chk("ar ir", ir1, 1);
    chk("ar occ", occ1, 0);
    chk("ar od", od1, 0);
    #1 rst = 1'b0;
    step();
    chk("ar stays empty", ov1, 0);

    // Bubble masking: load ctrl FFFF, consume, no new input
    r1 = 1; v1 = 1; d1 = 32'h33; c1 = 16'hFFFF;
    step();
    chk("bub ov", ov1, 1);
    chk("bub oc live", oc1, 16'hFFFF);
    v1 = 0;
    step();
    chk("bub ov gone", ov1, 0);
    chk("bub oc masked", oc1, 16'h0000);
    chk("bub od kept", od1, 32'h33);

    // SKID=0 throughput with out_ready toggling
    v0 = 1; d0 = 10; c0 = 16'h0101; r0 = 1;
    step();
    chk("s0 od 10", od0, 10);
    chk("s0 occ", occ0, 1);
    r0 = 0; d0 = 11;
    #1;
    chk("s0 ir follows 0", ir0, 0);
    step();
    chk("s0 od 10 held", od0, 10);
    chk("s0 occ max", occ0, 1);
    r0 = 1;
    #1;
    chk("s0 ir follows 1", ir0, 1);
    step();
    chk("s0 od 11", od0, 11);
    r0 = 0; d0 = 12;
    #1;
    chk("s0 ir follows 0b", ir0, 0);
    step();
    chk("s0 od 11 held", od0, 11);
    chk("s0 occ max b", occ0, 1);
    r0 = 1;
    step();
    chk("s0 od 12", od0, 12);
    chk("s0 oc live", oc0, 16'h0101);
    v0 = 0;
    step();
    chk("s0 ov drained", ov0, 0);
    chk("s0 oc bubble", oc0, 16'h5A5A);
    chk("s0 occ empty", occ0, 0);

    // SKID=0 flush
    v0 = 1; d0 = 32'h44; r0 = 0;
    step();
    chk("s0 fl load", ov0, 1);
    v0 = 0; f0 = 1;
    step();
    chk("s0 fl ov", ov0, 0);
    chk("s0 fl occ", occ0, 0);
    chk("s0 fl od", od0, 32'h44);
    f0 = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
